// File: rtl/sr_latch_driver_if.sv
// sr_latch_driver_if: command handshake plus latch drive/readback bundle for sr_latch_driver.
// Latency: none, wires only; all timing lives in the driver.
// Backpressure: CMD_VALID is held by the requester until CMD_READY accepts it.
// Signals: CMD_VALID/CMD_SET/CMD_READY handshake, Q_FB/QN_FB latch readback,
//          S/R latch drive, DONE/FAULT/LEVEL command result.
interface sr_latch_driver_if;
  logic CMD_VALID;
  logic CMD_SET;
  logic CMD_READY;
  logic Q_FB;
  logic QN_FB;
  logic S;
  logic R;
  logic DONE;
  logic FAULT;
  logic LEVEL;

  // Requester / latch environment side
  modport master (
    output CMD_VALID, CMD_SET, Q_FB, QN_FB,
    input  CMD_READY, S, R, DONE, FAULT, LEVEL
  );

  // Driver side
  modport slave (
    input  CMD_VALID, CMD_SET, Q_FB, QN_FB,
    output CMD_READY, S, R, DONE, FAULT, LEVEL
  );
endinterface

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: pulses S or R of an external SR latch, waits, then checks the Q/Qn readback.
// Latency: accept at edge k -> pulse k+1..k+PULSE_CYCLES, DONE at k+PULSE_CYCLES+GAP_CYCLES+1.
// Backpressure: CMD_READY only in IDLE; commands presented while busy are ignored, not queued.
// Ports: CLK (rising edge), RST_N (async active-low), bus (slave modport of sr_latch_driver_if):
//        CMD_VALID/CMD_SET in, CMD_READY out, Q_FB/QN_FB in, S/R/DONE/FAULT/LEVEL out (all registered).
module sr_latch_driver #(
  parameter int PULSE_CYCLES = 4,  // 1..255
  parameter int GAP_CYCLES   = 2   // 1..255
) (
  input logic           CLK,
  input logic           RST_N,
  sr_latch_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  // Counters count down to zero, so a phase of N cycles is loaded with N-1.
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tgt_q;
  logic       tgt_d;
  logic       ready_q;
  logic       s_q, r_q;
  logic       done_q;
  logic       fault_q;
  logic       level_q;
  logic       accept;
  logic       fb_bad;

  // ready_q is only ever high in IDLE, so it alone qualifies acceptance;
  // the state term keeps the intent explicit.
  assign accept = (state_q == IDLE) && ready_q && bus.CMD_VALID;

  // Target seen by the pulse outputs on the acceptance edge itself.
  assign tgt_d = accept ? bus.CMD_SET : tgt_q;

  // Readback is wrong if Q disagrees with the target, Qn is not its
  // complement, or both rails read the same value.
  assign fb_bad = (bus.Q_FB != tgt_q) || (bus.QN_FB != ~tgt_q) || (bus.Q_FB == bus.QN_FB);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PULSE;
          cnt_d   = PULSE_LOAD;
        end
      end
      PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = CHECK;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe; S and R are decoded from one target bit and can
  // never be high together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      tgt_q   <= 1'b0;
      ready_q <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      ready_q <= (state_d == IDLE);
      s_q     <= (state_d == PULSE) &&  tgt_d;
      r_q     <= (state_d == PULSE) && !tgt_d;
      done_q  <= (state_d == CHECK);
      if (accept) begin
        level_q <= bus.CMD_SET;
      end
      // Readback is sampled only on the edge that enters CHECK so FAULT
      // appears together with DONE and stays put until the next check.
      if (state_d == CHECK) begin
        fault_q <= fb_bad;
      end
    end
  end

  assign bus.CMD_READY = ready_q;
  assign bus.S         = s_q;
  assign bus.R         = r_q;
  assign bus.DONE      = done_q;
  assign bus.FAULT     = fault_q;
  assign bus.LEVEL     = level_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: drives a default instance (4/2) and a minimal instance (1/1) from shared stimulus.
// Latency: every output of both instances is compared once per cycle against a timeline model.
// Backpressure: requester stimulus may assert CMD_VALID at any time; the model decides acceptance.
module tb_sr_latch_driver;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic v = 1'b0;
  logic st = 1'b0;
  logic qf = 1'b1;
  logic qnf = 1'b0;

  always #5 CLK = ~CLK;

  sr_latch_driver_if ifa ();
  sr_latch_driver_if ifb ();

  assign ifa.CMD_VALID = v;
  assign ifa.CMD_SET   = st;
  assign ifa.Q_FB      = qf;
  assign ifa.QN_FB     = qnf;
  assign ifb.CMD_VALID = v;
  assign ifb.CMD_SET   = st;
  assign ifb.Q_FB      = qf;
  assign ifb.QN_FB     = qnf;

  sr_latch_driver #(.PULSE_CYCLES(4), .GAP_CYCLES(2)) dut_a (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (ifa.slave)
  );

  sr_latch_driver #(.PULSE_CYCLES(1), .GAP_CYCLES(1)) dut_b (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (ifb.slave)
  );

  // Timeline model: for each instance, a command accepted at edge k is
  // described by the edge numbers at which its events are observed.
  int pw [2] = '{4, 1};
  int gw [2] = '{2, 1};
  int free_at [2];
  int done_at [2];
  int s_lo [2];
  int s_hi [2];
  bit tgt [2];
  bit lvl [2];
  bit flt [2];
  bit in_rst;
  int e = 0;
  int total = 0;
  int bad = 0;
  int rst_hold = 0;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    in_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      free_at[i] = 1 << 30;
      done_at[i] = -10;
      s_lo[i] = 1;
      s_hi[i] = 0;
      tgt[i] = 1'b0;
      lvl[i] = 1'b0;
      flt[i] = 1'b0;
    end
  endtask

  // Compare observed outputs with the model for observation point n.
  task automatic check_all(input int n);
    logic o_s, o_r, o_d, o_f, o_l, o_y;
    for (int i = 0; i < 2; i++) begin
      o_s = (i == 0) ? ifa.S : ifb.S;
      o_r = (i == 0) ? ifa.R : ifb.R;
      o_d = (i == 0) ? ifa.DONE : ifb.DONE;
      o_f = (i == 0) ? ifa.FAULT : ifb.FAULT;
      o_l = (i == 0) ? ifa.LEVEL : ifb.LEVEL;
      o_y = (i == 0) ? ifa.CMD_READY : ifb.CMD_READY;
      chk($sformatf("S%0d@%0d", i, n), o_s, (n >= s_lo[i] && n <= s_hi[i] && tgt[i]));
      chk($sformatf("R%0d@%0d", i, n), o_r, (n >= s_lo[i] && n <= s_hi[i] && !tgt[i]));
      chk($sformatf("SR_excl%0d@%0d", i, n), o_s & o_r, 1'b0);
      chk($sformatf("DONE%0d@%0d", i, n), o_d, (n == done_at[i]));
      chk($sformatf("FAULT%0d@%0d", i, n), o_f, flt[i]);
      chk($sformatf("LEVEL%0d@%0d", i, n), o_l, lvl[i]);
      chk($sformatf("READY%0d@%0d", i, n), o_y, (n >= free_at[i]));
    end
  endtask

  // Readback is held steady around each check so its sampling edge is unambiguous.
  function automatic bit fb_ok(input int n);
    for (int i = 0; i < 2; i++)
      if (n == done_at[i] - 1 || n == done_at[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    if (!RST_N) return;
    if (in_rst) begin
      in_rst = 1'b0;
      for (int i = 0; i < 2; i++) free_at[i] = e + 1;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (e == done_at[i] - 1)
        flt[i] = !(qf == tgt[i] && qnf == !tgt[i]);
      if (v && e >= free_at[i]) begin
        tgt[i] = st;
        lvl[i] = st;
        s_lo[i] = e + 1;
        s_hi[i] = e + pw[i];
        done_at[i] = e + pw[i] + gw[i] + 1;
        free_at[i] = e + pw[i] + gw[i] + 2;
      end
    end
  endtask

  // One clock: check at the falling edge, drive inputs, advance model at the rising edge.
  task automatic step(input logic rst, input logic vv, input logic ss, input logic fq, input logic fqn);
    int n;
    @(negedge CLK);
    n = e + 1;
    check_all(n);
    if (!rst) begin
      if (RST_N) model_reset();
      RST_N = 1'b0;
    end else begin
      RST_N = 1'b1;
    end
    v = vv;
    st = ss;
    if (fb_ok(n)) begin
      qf = fq;
      qnf = fqn;
    end
    @(posedge CLK);
    e++;
    model_edge();
  endtask

  // Assert reset mid-cycle and confirm the outputs clear without waiting for a clock.
  task automatic async_rst();
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_all(e + 1);
  endtask

  initial begin
    model_reset();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);

    // Good set command, then idle through completion.
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 1, 1, 0);

    // Reset command against a latch that still reads set: fault.
    step(1, 1, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 0);

    // Good set command clears the fault; repeated level still pulses.
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 0);

    // Both rails high: fault for either target; inputs toggle while busy.
    step(1, 0, 0, 1, 1);
    for (int i = 0; i < 12; i++) step(1, 1'(i % 2 == 0), 1'(i % 3 == 0), 1, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 0);

    // Reset during the second pulse cycle aborts the command.
    step(1, 1, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    async_rst();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        step(rst_hold == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 99) == 0) begin
        async_rst();
        rst_hold = $urandom_range(1, 3);
      end else begin
        step(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 4, giving the S/R pulse width in clock cycles (legal 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, giving the idle settle cycles after a pulse before the check (legal 1..255).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port CMD_VALID  input  1  command request.
REQ-006 SHALL have port CMD_SET  input  1  command level: 1 = set the latch, 0 = reset it; sampled on acceptance only.
REQ-007 SHALL have port CMD_READY  output  1  driver idle and able to accept a command.
REQ-008 SHALL have port Q_FB  input  1  latch Q readback, synchronous to CLK.
REQ-009 SHALL have port QN_FB  input  1  latch Qn readback, synchronous to CLK.
REQ-010 SHALL have port S  output  1  set pulse to the SR latch.
REQ-011 SHALL have port R  output  1  reset pulse to the SR latch.
REQ-012 SHALL have port DONE  output  1  one-cycle strobe when a command's check completes.
REQ-013 SHALL have port FAULT  output  1  result of the most recent check; 1 = readback wrong.
REQ-014 SHALL have port LEVEL  output  1  last accepted CMD_SET value.

Function
REQ-015 SHALL implement FSM states IDLE, PULSE, GAP, CHECK. All outputs SHALL be registered.
REQ-016 SHALL assert CMD_READY only in IDLE. A command is accepted on a rising edge with CMD_VALID=1 and CMD_READY=1.
REQ-017 On acceptance, SHALL capture CMD_SET into LEVEL and the target register, go to PULSE, and load an 8-bit down-counter.
REQ-018 For a command accepted at edge k, SHALL drive S (target=1) or R (target=0) high for exactly PULSE_CYCLES cycles, k+1..k+PULSE_CYCLES.
REQ-019 SHALL never drive S and R high in the same cycle, under any input or reset sequence.
REQ-020 SHALL then hold S=R=0 for exactly GAP_CYCLES cycles (GAP state).
REQ-021 SHALL spend one cycle in CHECK, at k+PULSE_CYCLES+GAP_CYCLES+1: assert DONE, set FAULT=1 if Q_FB!=target, QN_FB!=~target, or Q_FB==QN_FB, otherwise FAULT=0.
REQ-022 SHALL return to IDLE after CHECK, with CMD_READY=1 at k+PULSE_CYCLES+GAP_CYCLES+2. Total command period SHALL be PULSE_CYCLES+GAP_CYCLES+2 cycles.
REQ-023 SHALL ignore CMD_VALID and CMD_SET while not in IDLE. No queuing: the requester holds CMD_VALID until accepted.
REQ-024 SHALL hold FAULT and LEVEL stable between checks. FAULT SHALL be updated only in CHECK.
REQ-025 SHALL ignore Q_FB and QN_FB outside CHECK.
REQ-026 A command repeating the current LEVEL SHALL still produce the full pulse/gap/check sequence.
REQ-027 Back-to-back commands SHALL be spaced by at least one IDLE cycle with CMD_READY=1.

Reset
REQ-028 While RST_N=0, asynchronously and immediately: state=IDLE, S=0, R=0, DONE=0, FAULT=0, LEVEL=0, counter=0.
REQ-029 CMD_READY SHALL read 0 while RST_N=0 and go to 1 on the first rising edge after RST_N deasserts.
REQ-030 Reset mid-PULSE SHALL terminate the pulse immediately, and the aborted command SHALL produce no DONE.

Verification
REQ-031 Defaults: RST_N release, CMD_VALID=1, CMD_SET=1 at edge k, Q_FB=1, QN_FB=0 -> S high k+1..k+4, S=R=0 k+5..k+6, DONE=1 at k+7 with FAULT=0, LEVEL=1, CMD_READY=1 at k+8.
REQ-032 CMD_SET=0 with Q_FB=1, QN_FB=0 held -> R high 4 cycles, S never high, DONE with FAULT=1. Next good set command clears FAULT to 0.
REQ-033 Q_FB=QN_FB=1 during CHECK -> FAULT=1 regardless of target.
REQ-034 Toggle CMD_VALID and CMD_SET every cycle while busy -> no extra pulses, CMD_READY=0 until k+8, exactly one DONE.
REQ-035 RST_N low at pulse cycle 2 -> S=0 in the same cycle (asynchronous), no DONE, FAULT=0, LEVEL=0. Recovery command completes normally.
REQ-036 PULSE_CYCLES=1, GAP_CYCLES=1 -> 1-cycle pulse, DONE at k+3, CMD_READY at k+4. Assertion checked every cycle: never S&&R.
